// File: rtl/apb_multi_slave_top.sv
// rtl/apb_multi_slave_top.sv - command-driven APB master with decoded register-file slaves
module apb_multi_slave_top #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int NUM_SLAVES     = 2,
    parameter int REGS_PER_SLAVE = 4,
    parameter int WAIT_STATES    = 1
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic [1:0]              cmd_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   external_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] strb_i,
    output logic                    ready_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    output logic                    busy_o
);
    localparam int REG_IDX_W = $clog2(REGS_PER_SLAVE);
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int NUM_WORDS = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NUM_BYTES-1:0]    strb_q;
    logic                    write_q;
    logic                    psel_q;
    logic                    penable_q;
    logic [3:0]              wait_cnt_q;
    logic                    ready_q;
    logic                    err_q;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_WORDS];

    logic                    pready;
    logic                    pslverr;

    function automatic logic is_mapped(input logic [ADDR_WIDTH-1:0] a);
        logic [31:0] slave_idx;
        slave_idx = 32'(a) >> REG_IDX_W;
        return slave_idx < 32'(NUM_SLAVES);
    endfunction

    // With no psel asserted the default responder answers at once with an error.
    assign pready  = penable_q & (psel_q ? (wait_cnt_q == 4'(WAIT_STATES)) : 1'b1);
    assign pslverr = ~psel_q;

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            write_q    <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            wait_cnt_q <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            rdata_q    <= '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cmd_i[0]) begin
                        addr_q  <= addr_i;
                        wdata_q <= external_wdata_i;
                        strb_q  <= strb_i;
                        write_q <= cmd_i[1];
                        psel_q  <= is_mapped(addr_i);
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q  <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        if (psel_q) begin
                            if (write_q) begin
                                for (int b = 0; b < NUM_BYTES; b++) begin
                                    if (strb_q[b]) begin
                                        regs_q[addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
                                    end
                                end
                            end else begin
                                rdata_q <= regs_q[addr_q];
                            end
                        end else if (!write_q) begin
                            rdata_q <= '0;
                        end
                        ready_q   <= 1'b1;
                        err_q     <= pslverr;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign err_o   = err_q;
    assign busy_o  = busy_q;
    assign rdata_o = rdata_q;
endmodule

// File: tb/tb_apb_multi_slave_top.sv
// tb/tb_apb_multi_slave_top.sv - directed and randomized checks of apb_multi_slave_top against a transaction model
module tb_apb_multi_slave_top;
    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int NS  = 2;
    localparam int RPS = 4;
    localparam int WS  = 1;

    logic          pclk     = 1'b0;
    logic          preset_n = 1'b0;
    logic [1:0]    cmd_i    = 2'b00;
    logic [AW-1:0] addr_i   = '0;
    logic [DW-1:0] wdata_i  = '0;
    logic [3:0]    strb_i   = '0;
    logic          ready_o;
    logic          err_o;
    logic          busy_o;
    logic [DW-1:0] rdata_o;

    int checks   = 0;
    int failures = 0;

    always #5 pclk = ~pclk;

    apb_multi_slave_top #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLAVES(NS),
        .REGS_PER_SLAVE(RPS), .WAIT_STATES(WS)
    ) dut (
        .pclk(pclk), .preset_n(preset_n), .cmd_i(cmd_i), .addr_i(addr_i),
        .external_wdata_i(wdata_i), .strb_i(strb_i), .ready_o(ready_o),
        .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: each accepted command completes a fixed number of edges later.
    int          cyc        = 0;
    int          done_edge  = -10;
    bit          pend       = 1'b0;
    bit          pend_read  = 1'b0;
    bit          last_err   = 1'b0;
    bit          chk_en     = 1'b0;
    logic [31:0] pend_rdata = '0;
    logic [31:0] m_rdata    = '0;
    logic [31:0] m_regs [16];

    always @(posedge pclk) begin
        cyc++;
        if (!preset_n) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_rdata   = '0;
            pend      = 1'b0;
            done_edge = -10;
            chk_en    = 1'b1;
        end else if (pend) begin
            if (cyc == done_edge) begin
                pend = 1'b0;
                if (pend_read) m_rdata = pend_rdata;
            end
        end else if ((cmd_i == 2'b01 || cmd_i == 2'b11) && cyc >= done_edge + 2) begin
            int a;
            bit mapped;
            a         = int'(addr_i);
            mapped    = (a / RPS) < NS;
            done_edge = cyc + (mapped ? 2 + WS : 2);
            pend      = 1'b1;
            last_err  = !mapped;
            pend_read = (cmd_i == 2'b01);
            if (!mapped) begin
                pend_rdata = '0;
            end else if (pend_read) begin
                pend_rdata = m_regs[a];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (strb_i[b]) m_regs[a][8*b +: 8] = wdata_i[8*b +: 8];
            end
        end
    end

    always @(negedge pclk) begin
        if (chk_en) begin
            check("ready", ready_o, cyc == done_edge);
            check("err", err_o, (cyc == done_edge) && last_err);
            check("busy", busy_o, pend);
            check("rdata", rdata_o, m_rdata);
        end
    end

    task automatic xfer(input logic [1:0] cmd, input logic [3:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input bit hold,
                        output int lat, output bit err, output int busy_cnt, output int ready_cnt);
        @(negedge pclk);
        cmd_i = cmd; addr_i = addr; wdata_i = wd; strb_i = strb;
        @(posedge pclk);
        lat = 0; err = 1'b0; busy_cnt = 0; ready_cnt = 0;
        @(negedge pclk);
        busy_cnt += int'(busy_o);
        if (!hold) cmd_i = 2'b00;
        for (int n = 1; n <= 40; n++) begin
            @(posedge pclk);
            @(negedge pclk);
            busy_cnt += int'(busy_o);
            if (ready_o) begin
                ready_cnt++;
                if (lat == 0) begin
                    lat = n;
                    err = err_o;
                end
            end
            if (!hold || (lat != 0 && n > lat)) cmd_i = 2'b00;
            if (lat != 0 && n >= lat + 2) break;
        end
        cmd_i = 2'b00;
        check("xfer_completed", lat != 0, 1'b1);
    endtask

    initial begin
        int lat, busy_cnt, ready_cnt;
        bit err;
        bit seen;

        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("rst_ready", ready_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_rdata", rdata_o, 32'h0);
        preset_n = 1'b1;

        xfer(2'b01, 4'h0, 32'h0, 4'h0, 0, lat, err, busy_cnt, ready_cnt);
        check("rd0_data", rdata_o, 32'h0);
        check("rd0_err", err, 1'b0);

        xfer(2'b11, 4'h1, 32'hDEADBEEF, 4'hF, 0, lat, err, busy_cnt, ready_cnt);
        check("wr1_latency", lat, 3);
        check("wr1_err", err, 1'b0);
        check("wr1_busy_cycles", busy_cnt, 3);
        check("wr1_ready_pulses", ready_cnt, 1);
        xfer(2'b01, 4'h1, 32'h0, 4'h0, 0, lat, err, busy_cnt, ready_cnt);
        check("rd1_data", rdata_o, 32'hDEADBEEF);
        check("model_rd1_data", m_rdata, 32'hDEADBEEF);
        check("rd1_latency", lat, 3);

        xfer(2'b11, 4'h5, 32'h12345678, 4'hF, 0, lat, err, busy_cnt, ready_cnt);
        xfer(2'b01, 4'h1, 32'h0, 4'h0, 0, lat, err, busy_cnt, ready_cnt);
        check("alias_rd1", rdata_o, 32'hDEADBEEF);
        xfer(2'b01, 4'h5, 32'h0, 4'h0, 0, lat, err, busy_cnt, ready_cnt);
        check("alias_rd5", rdata_o, 32'h12345678);

        xfer(2'b11, 4'h1, 32'hAABBCCDD, 4'b0101, 0, lat, err, busy_cnt, ready_cnt);
        xfer(2'b01, 4'h1, 32'h0, 4'h0, 0, lat, err, busy_cnt, ready_cnt);
        check("strb_rd1", rdata_o, 32'hDEBBBEDD);
        xfer(2'b11, 4'h1, 32'h01020304, 4'h0, 0, lat, err, busy_cnt, ready_cnt);
        check("strb0_err", err, 1'b0);
        xfer(2'b01, 4'h1, 32'h0, 4'h0, 0, lat, err, busy_cnt, ready_cnt);
        check("strb0_rd1", rdata_o, 32'hDEBBBEDD);
        check("model_strb0_rd1", m_rdata, 32'hDEBBBEDD);

        xfer(2'b11, 4'h9, 32'h55555555, 4'hF, 0, lat, err, busy_cnt, ready_cnt);
        check("unmapped_wr_latency", lat, 2);
        check("unmapped_wr_err", err, 1'b1);
        xfer(2'b01, 4'h9, 32'h0, 4'h0, 0, lat, err, busy_cnt, ready_cnt);
        check("unmapped_rd_data", rdata_o, 32'h0);
        check("unmapped_rd_err", err, 1'b1);
        check("unmapped_rd_latency", lat, 2);

        @(negedge pclk);
        cmd_i = 2'b10;
        seen = 1'b0;
        repeat (5) begin
            @(negedge pclk);
            seen |= busy_o;
        end
        cmd_i = 2'b00;
        check("reserved_cmd_busy", seen, 1'b0);

        xfer(2'b11, 4'h2, 32'hCAFEF00D, 4'hF, 1, lat, err, busy_cnt, ready_cnt);
        check("held_cmd_ready_pulses", ready_cnt, 1);
        xfer(2'b01, 4'h2, 32'h0, 4'h0, 0, lat, err, busy_cnt, ready_cnt);
        check("held_rd2", rdata_o, 32'hCAFEF00D);

        @(negedge pclk);
        cmd_i = 2'b11; addr_i = 4'h3; wdata_i = 32'h11112222; strb_i = 4'hF;
        @(posedge pclk);
        @(negedge pclk);
        cmd_i = 2'b00;
        @(posedge pclk);
        @(negedge pclk);
        preset_n = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        check("midrst_ready", ready_o, 1'b0);
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_rdata", rdata_o, 32'h0);
        preset_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge pclk);
            seen |= ready_o;
        end
        check("midrst_no_ready", seen, 1'b0);
        xfer(2'b01, 4'h1, 32'h0, 4'h0, 0, lat, err, busy_cnt, ready_cnt);
        check("midrst_rd1_cleared", rdata_o, 32'h0);
        xfer(2'b01, 4'h3, 32'h0, 4'h0, 0, lat, err, busy_cnt, ready_cnt);
        check("midrst_rd3_cleared", rdata_o, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge pclk);
            preset_n = ($urandom_range(0, 299) != 0);
            cmd_i    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
            addr_i   = 4'($urandom);
            wdata_i  = $urandom;
            strb_i   = 4'($urandom);
        end
        @(negedge pclk);
        preset_n = 1'b1;
        cmd_i    = 2'b00;
        repeat (10) @(negedge pclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_multi_slave_top.md
Name: apb_multi_slave_top

Overview:
Parametrised APB subsystem. It contains a command-driven APB master FSM, an address decoder, NUM_SLAVES register-file slaves with configurable wait states, and a default error responder for unmapped addresses. It is the generalised successor of the single-slave apb_top and keeps the same command encoding and handshake. It adds addressing, byte strobes, multiple slaves, wait states and error reporting.

Parameters:
DATA_WIDTH, 32, data bus width; must be a multiple of 8
ADDR_WIDTH, 4, word address width of addr_i
NUM_SLAVES, 2, number of register-file slaves; 1..2^(ADDR_WIDTH-REG_IDX_W)
REGS_PER_SLAVE, 4, registers per slave; power of two; REG_IDX_W = clog2(REGS_PER_SLAVE)
WAIT_STATES, 1, extra ACCESS cycles every mapped slave inserts before pready; 0..15

Ports:
pclk  in  1  clock
preset_n  in  1  reset, synchronous, active-low
cmd_i  in  2  command: 00 idle, 01 read, 11 write, 10 reserved (treated as idle)
addr_i  in  ADDR_WIDTH  word address: [ADDR_WIDTH-1:REG_IDX_W] selects the slave, [REG_IDX_W-1:0] selects the register
external_wdata_i  in  DATA_WIDTH  write data
strb_i  in  DATA_WIDTH/8  write byte strobes; ignored on reads
ready_o  out  1  one-cycle transfer-complete pulse
rdata_o  out  DATA_WIDTH  last completed read data
err_o  out  1  error flag, valid only while ready_o=1
busy_o  out  1  high in SETUP and ACCESS

Behaviour:
- Reset (preset_n=0 sampled at posedge):
  - FSM goes to IDLE.
  - All slave registers are cleared to 0.
  - ready_o, err_o, busy_o and rdata_o go to 0.
  - Internal psel/penable/wait counter are cleared.
  - Reset overrides any in-flight transfer; no ready_o pulse follows.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - cmd_i 01 or 11 at posedge: latch addr, wdata, strb and the write flag, then go to SETUP.
  - cmd_i 00 or 10: stay in IDLE.
- SETUP: psel=1 for the decoded slave, penable=0; always go to ACCESS next edge. Wait counter is cleared.
- ACCESS:
  - psel=1, penable=1.
  - A mapped slave drives pready=1 when its counter equals WAIT_STATES; otherwise the counter increments.
  - On an edge with pready=1: go to DONE and register ready_o=1, err_o=pslverr.
- DONE: ready_o=1 for exactly this cycle. cmd_i is ignored here, so a held command does not retrigger. Go to IDLE at the next edge.
- Command changes while busy are ignored; the latched values are used.
- Latency, with acceptance edge E:
  - Mapped slave: ready_o high during the cycle after edge E+2+WAIT_STATES.
  - Unmapped slave: ready_o high after edge E+2.
- Decode: slave index >= NUM_SLAVES is unmapped. No slave psel is driven; the default responder returns pready=1 in the first ACCESS cycle with pslverr=1.
- Mapped writes:
  - Update register bytes where strb bit=1 at the pready edge; other bytes are unchanged.
  - strb=0 is legal: no change, err_o=0.
  - rdata_o is unchanged.
- Mapped reads: rdata_o is loaded with the register value at the pready edge, err_o=0.
- Unmapped transfers:
  - Unmapped write: no state change, err_o=1.
  - Unmapped read: rdata_o=0, err_o=1.
- rdata_o holds its value between reads.
- err_o is 0 whenever ready_o is 0.
- Widths: addr_i is a word address (no byte offset bits). Slaves do not alias each other.

Test Plan:
- Reset → ready_o, err_o, busy_o all 0; rdata_o=0. Read addr 0x0 → rdata_o=0x00000000, err_o=0.
- Write 0xDEADBEEF to 0x1, strb 0xF, WAIT_STATES=1 → ready_o one cycle, 3 edges after acceptance, err_o=0. Read 0x1 → rdata_o=0xDEADBEEF. busy_o high exactly 3 cycles per transfer.
- Write 0x12345678 to 0x5 (slave 1, reg 1) → read 0x1 returns 0xDEADBEEF and read 0x5 returns 0x12345678 (no aliasing).
- Write 0xAABBCCDD to 0x1 with strb 0b0101 → read 0x1 returns 0xDEBBBEDD. Write with strb 0x0 → value unchanged, err_o=0.
- Write to 0x9 (slave 2, unmapped) → ready_o 2 edges after acceptance, err_o=1. Read 0x9 → rdata_o=0, err_o=1.
- cmd_i=10 for 5 cycles → busy_o stays 0. cmd_i=11 held through DONE → exactly one ready_o pulse.
- preset_n low during ACCESS → at next edge all outputs 0, registers cleared, no ready_o pulse.
